// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory port arbiter.
// Imported by the interface, the picker and the arbiter top.
package mem_arb_pkg;

   localparam int NUM_PORTS  = 4;
   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   // Low bit of port idx's slice inside a packed multi-port bus.
   function automatic int slice_lo(input logic [1:0] idx, input int width);
      return int'(idx) * width;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake and memory_controller-side command bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic [NUM_PORTS-1:0]        req;
   logic [NUM_PORTS-1:0]        we;
   logic [NUM_PORTS*ADDR_W-1:0] req_addr;
   logic [NUM_PORTS*DATA_W-1:0] req_wdata;
   logic [NUM_PORTS-1:0]        ack;
   logic [NUM_PORTS*DATA_W-1:0] rdata;

   logic [1:0]                  mc_state;
   logic                        mc_en;
   logic [NUM_PORTS-1:0]        mc_read;
   logic [NUM_PORTS-1:0]        mc_write;
   logic [NUM_PORTS*ADDR_W-1:0] mc_address;
   logic [NUM_PORTS*DATA_W-1:0] mc_wdata;
   logic [NUM_PORTS*DATA_W-1:0] mc_rdata;

   modport slave (
      input  req, we, req_addr, req_wdata, mc_rdata,
      output ack, rdata, mc_state, mc_en, mc_read, mc_write, mc_address, mc_wdata
   );

   modport master (
      output req, we, req_addr, req_wdata, mc_rdata,
      input  ack, rdata, mc_state, mc_en, mc_read, mc_write, mc_address, mc_wdata
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching from
// last_grant+1 upward (mod 4); last_grant itself has the lowest priority.
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [1:0]           last_grant_i,
   output logic                 valid_o,
   output logic [1:0]           idx_o
);

   logic [1:0] cand [NUM_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
         assign cand[gi] = last_grant_i + 2'(gi + 1);
      end
   endgenerate

   // Walk from lowest to highest priority so the nearest requester wins.
   always_comb begin
      idx_o = cand[0];
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req_i[cand[k]]) begin
            idx_o = cand[k];
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin front end for memory_controller: grants one of four requesters,
// holds its command for MEM_LATENCY cycles, then returns read data and an ack.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);

   arb_state_e        state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        last_grant_q, last_grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q [NUM_PORTS];
   logic [DATA_W-1:0] rdata_d [NUM_PORTS];

   logic              pick_valid;
   logic [1:0]        pick_idx;
   logic              issue_active;
   logic              resp_active;

   rr_pick u_rr_pick (
      .req_i        (bus.req),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid),
      .idx_o        (pick_idx)
   );

   // last_grant resets to 3 so that port 0 is first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         last_grant_q <= 2'd3;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            rdata_q[p] <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               idx_d   = pick_idx;
               we_d    = bus.we[pick_idx];
               addr_d  = bus.req_addr[slice_lo(pick_idx, ADDR_W) +: ADDR_W];
               wdata_d = bus.req_wdata[slice_lo(pick_idx, DATA_W) +: DATA_W];
               cnt_d   = CNT_W'(MEM_LATENCY - 1);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // The controller's output is only trusted on the final hold cycle.
            if (cnt_q == '0) begin
               if (!we_q) begin
                  rdata_d[idx_q] = bus.mc_rdata[slice_lo(idx_q, DATA_W) +: DATA_W];
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            last_grant_d = idx_q;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign issue_active = (state_q == ISSUE);
   assign resp_active  = (state_q == RESP);
   assign bus.mc_en    = issue_active;
   assign bus.mc_state = idx_q;

   // Command lines decode straight from reset-cleared registers, so a reset
   // mid-transaction drops them without waiting for a clock edge.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         logic sel;
         assign sel = issue_active && (idx_q == 2'(gi));

         assign bus.mc_read[gi]  = sel && !we_q;
         assign bus.mc_write[gi] = sel && we_q;
         assign bus.mc_address[gi*ADDR_W +: ADDR_W] = sel ? addr_q : '0;
         assign bus.mc_wdata[gi*DATA_W +: DATA_W]   = sel ? wdata_q : '0;
         assign bus.ack[gi] = resp_active && (idx_q == 2'(gi));
         assign bus.rdata[gi*DATA_W +: DATA_W]      = rdata_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (latency 2, 1, 15) exercised by
// directed and random requests against a transaction-level reference model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int NDUT = 3;
   localparam int AW   = 7;
   localparam int DW   = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]      req_s   [NDUT];
   logic [3:0]      we_s    [NDUT];
   logic [4*AW-1:0] addr_s  [NDUT];
   logic [4*DW-1:0] wdata_s [NDUT];
   logic [3:0]      ack_s   [NDUT];
   logic [3:0]      rd_s    [NDUT];
   logic [3:0]      wr_s    [NDUT];
   logic [4*DW-1:0] rdata_s [NDUT];
   logic [4*DW-1:0] mwd_s   [NDUT];
   logic [4*AW-1:0] mad_s   [NDUT];
   logic [1:0]      mcst_s  [NDUT];
   logic            en_s    [NDUT];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   genvar gi;
   for (gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);

      mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

      logic [7:0]      mem [128];
      bit              mem_init = 1'b0;
      int unsigned     en_cnt = 0;
      logic [4*DW-1:0] mc_rdata_m;

      mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );

      assign bus.req       = req_s[gi];
      assign bus.we        = we_s[gi];
      assign bus.req_addr  = addr_s[gi];
      assign bus.req_wdata = wdata_s[gi];
      assign bus.mc_rdata  = mc_rdata_m;
      assign ack_s[gi]     = bus.ack;
      assign rd_s[gi]      = bus.mc_read;
      assign wr_s[gi]      = bus.mc_write;
      assign rdata_s[gi]   = bus.rdata;
      assign mwd_s[gi]     = bus.mc_wdata;
      assign mad_s[gi]     = bus.mc_address;
      assign mcst_s[gi]    = bus.mc_state;
      assign en_s[gi]      = bus.mc_en;

      // Memory controller stand-in: read data is only valid once the command
      // has been held for LAT cycles, garbage (inverted) before that.
      always @(posedge clk) begin
         if (!mem_init) begin
            for (int a = 0; a < 128; a++) mem[a] <= 8'(a * 37 + 5);
            mem_init <= 1'b1;
         end else begin
            for (int p = 0; p < 4; p++)
               if (bus.mc_en && bus.mc_write[p])
                  mem[bus.mc_address[p*AW +: AW]] <= bus.mc_wdata[p*DW +: DW];
         end
         en_cnt <= bus.mc_en ? en_cnt + 1 : 0;
      end

      always_comb begin
         mc_rdata_m = '0;
         for (int p = 0; p < 4; p++)
            if (bus.mc_read[p])
               mc_rdata_m[p*DW +: DW] = (en_cnt == LAT - 1) ? mem[bus.mc_address[p*AW +: AW]]
                                                            : ~mem[bus.mc_address[p*AW +: AW]];
      end
   end

   // Reference model state
   int            lastg   [NDUT];
   bit            pend    [NDUT][4];
   bit            pwe     [NDUT][4];
   logic [AW-1:0] paddr   [NDUT][4];
   logic [DW-1:0] pwd     [NDUT][4];
   logic [DW-1:0] ref_mem [NDUT][128];
   logic [DW-1:0] ref_rd  [NDUT][4];
   int            waits   [NDUT][4];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         lastg[d]   = 3;
         req_s[d]   = '0;
         we_s[d]    = '0;
         addr_s[d]  = '0;
         wdata_s[d] = '0;
         for (int p = 0; p < 4; p++) begin
            pend[d][p]   = 1'b0;
            ref_rd[d][p] = '0;
            waits[d][p]  = 0;
         end
      end
   endtask

   task automatic check_zero(input int d);
      chk("zero_ack",   ack_s[d], 0);
      chk("zero_en",    en_s[d], 0);
      chk("zero_rw",    {rd_s[d], wr_s[d]}, 0);
      chk("zero_addr",  mad_s[d], 0);
      chk("zero_wdata", mwd_s[d], 0);
      chk("zero_state", mcst_s[d], 0);
      chk("zero_rdata", rdata_s[d], 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      tick();
      tick();
      for (int d = 0; d < NDUT; d++) check_zero(d);
      rst_n = 1'b1;
      tick();
      for (int d = 0; d < NDUT; d++) check_zero(d);
   endtask

   task automatic post(input int d, input int p, input bit w,
                       input logic [AW-1:0] a, input logic [DW-1:0] v);
      pend[d][p]  = 1'b1;
      pwe[d][p]   = w;
      paddr[d][p] = a;
      pwd[d][p]   = v;
      req_s[d][p] = 1'b1;
      we_s[d][p]  = w;
      addr_s[d][p*AW +: AW]  = a;
      wdata_s[d][p*DW +: DW] = v;
   endtask

   function automatic int model_pick(input int d);
      for (int k = 1; k <= 4; k++) begin
         int p;
         p = (lastg[d] + k) % 4;
         if (pend[d][p]) return p;
      end
      return 0;
   endfunction

   // One complete transaction from the IDLE cycle through to the next IDLE.
   task automatic serve(input int d, input bit drop_early, output int w, output int unsigned ack_cyc);
      int L;
      logic [4*AW-1:0] exp_a;
      logic [4*DW-1:0] exp_v;
      L = lat_of(d);
      w = model_pick(d);
      exp_a = '0;
      exp_a[w*AW +: AW] = paddr[d][w];
      exp_v = '0;
      exp_v[w*DW +: DW] = pwd[d][w];
      tick();
      for (int c = 0; c < L; c++) begin
         chk("issue_en",    en_s[d], 1);
         chk("issue_state", mcst_s[d], w);
         chk("issue_read",  rd_s[d], pwe[d][w] ? 0 : (4'b1 << w));
         chk("issue_write", wr_s[d], pwe[d][w] ? (4'b1 << w) : 0);
         chk("issue_addr",  mad_s[d], exp_a);
         chk("issue_wdata", mwd_s[d], exp_v);
         chk("issue_noack", ack_s[d], 0);
         if (c == 0) begin
            we_s[d][w] = ~we_s[d][w];
            addr_s[d][w*AW +: AW]  = ~paddr[d][w];
            wdata_s[d][w*DW +: DW] = ~pwd[d][w];
            if (drop_early) req_s[d][w] = 1'b0;
         end
         tick();
      end
      if (pwe[d][w]) ref_mem[d][paddr[d][w]] = pwd[d][w];
      else           ref_rd[d][w] = ref_mem[d][paddr[d][w]];
      chk("resp_ack",   ack_s[d], 4'b1 << w);
      chk("resp_en",    en_s[d], 0);
      chk("resp_rw",    {rd_s[d], wr_s[d]}, 0);
      chk("resp_addr",  mad_s[d], 0);
      chk("resp_wdata", mwd_s[d], 0);
      chk("resp_rdata", rdata_s[d], {ref_rd[d][3], ref_rd[d][2], ref_rd[d][1], ref_rd[d][0]});
      ack_cyc = cyc;
      req_s[d][w] = 1'b0;
      pend[d][w]  = 1'b0;
      waits[d][w] = 0;
      for (int p = 0; p < 4; p++) begin
         if (pend[d][p]) begin
            waits[d][p]++;
            chk("rr_wait_bound", (waits[d][p] <= 3), 1);
         end
      end
      lastg[d] = w;
      tick();
      chk("idle_ack",   ack_s[d], 0);
      chk("idle_en",    en_s[d], 0);
      chk("idle_state", mcst_s[d], w);
   endtask

   task automatic run_random(input int d, input int n);
      int w;
      int unsigned t;
      for (int i = 0; i < n; i++) begin
         for (int p = 0; p < 4; p++)
            if (!pend[d][p] && $urandom_range(0, 1) == 1)
               post(d, p, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom));
         if (!(pend[d][0] || pend[d][1] || pend[d][2] || pend[d][3]))
            post(d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 7'($urandom_range(0, 15)), 8'($urandom));
         serve(d, 1'($urandom_range(0, 1)), w, t);
      end
      for (int i = 0; i < 4; i++)
         if (pend[d][0] || pend[d][1] || pend[d][2] || pend[d][3])
            serve(d, 1'b0, w, t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int unsigned t0, t1;
      int exp_seq [4];

      for (int d = 0; d < NDUT; d++)
         for (int a = 0; a < 128; a++)
            ref_mem[d][a] = 8'(a * 37 + 5);
      model_reset();
      do_reset();

      // Single write, then read it back on another port
      post(0, 0, 1'b1, 7'd10, 8'd10);
      serve(0, 1'b0, w, t0);
      chk("wr_grant", w, 0);
      post(0, 1, 1'b0, 7'd10, 8'h00);
      serve(0, 1'b0, w, t0);
      chk("rd_grant", w, 1);
      chk("rd_slice1", rdata_s[0][15:8], 8'd10);
      tick();
      chk("rd_hold", rdata_s[0][15:8], 8'd10);

      // Full contention from reset: strict order, fixed spacing
      do_reset();
      for (int p = 0; p < 4; p++) post(0, p, 1'(p % 2), 7'(20 + p), 8'(p * 17 + 1));
      exp_seq = '{0, 1, 2, 3};
      t0 = 0;
      for (int i = 0; i < 4; i++) begin
         serve(0, 1'b0, w, t1);
         chk("cont_order", w, exp_seq[i]);
         if (i > 0) chk("cont_spacing", t1 - t0, 4);
         t0 = t1;
      end

      // Two ports re-requesting immediately alternate
      post(0, 0, 1'b1, 7'd30, 8'h11);
      post(0, 2, 1'b0, 7'd30, 8'h00);
      exp_seq = '{0, 2, 0, 2};
      for (int i = 0; i < 4; i++) begin
         serve(0, 1'b0, w, t0);
         chk("fair_order", w, exp_seq[i]);
         if (i < 3) post(0, w, 1'b0, 7'd30, 8'h00);
      end
      serve(0, 1'b0, w, t0);
      chk("fair_drain", w, 0);

      // Request dropped and inputs scribbled mid-transaction
      post(0, 1, 1'b0, 7'd10, 8'h00);
      serve(0, 1'b1, w, t0);
      chk("drop_grant", w, 1);
      chk("drop_rdata", rdata_s[0][15:8], 8'd10);

      // Reset during ISSUE aborts at once and restarts priority at port 0
      post(0, 3, 1'b1, 7'd50, 8'hA5);
      tick();
      chk("mid_en", en_s[0], 1);
      rst_n = 1'b0;
      #1;
      check_zero(0);
      tick();
      chk("mid_noack", ack_s[0], 0);
      rst_n = 1'b1;
      model_reset();
      tick();
      post(0, 3, 1'b0, 7'd50, 8'h00);
      post(0, 0, 1'b0, 7'd10, 8'h00);
      serve(0, 1'b0, w, t0);
      chk("post_rst_grant", w, 0);
      serve(0, 1'b0, w, t0);
      chk("post_rst_next", w, 3);

      run_random(0, 40);

      // Latency sweep instances
      for (int d = 1; d < NDUT; d++) begin
         post(d, 2, 1'b1, 7'd3, 8'h3C);
         serve(d, 1'b0, w, t0);
         chk("sweep_wr_grant", w, 2);
         post(d, 2, 1'b0, 7'd3, 8'h00);
         serve(d, 1'b0, w, t0);
         chk("sweep_rd_data", rdata_s[d][23:16], 8'h3C);
         run_random(d, (d == 1) ? 30 : 8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
